uart_tx_fifo: RTL and testbench

- Serial UART transmitter, directly downstream of the baud-rate divider in the ADC readout path.
- Accepts bytes (e.g. ADC sample bytes) on a valid/ready interface and buffers them in a small FIFO.
- Serialises frames (start, data LSB-first, optional parity, stop) on txd.
- Bit timing comes only from the single-cycle baud_tick enable supplied by the divider stage.

---
 rtl/uart_tx_fifo.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of it.
// Bytes are taken on a valid/ready interface, queued, and sent as frames:
// start, data LSB-first, optional parity, then stop bits.
// All line timing comes from the single-cycle baud_tick enable.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_tick,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DepthCount = CW'(FIFO_DEPTH);
    localparam logic [3:0]    NumData    = 4'(DATA_BITS);
    localparam logic [1:0]    NumStop    = 2'(STOP_BITS);
    // Seed for the running XOR: 1 turns the result into odd parity.
    localparam logic          ParInit    = (PARITY == 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign s_ready    = (count_q != DepthCount);
    assign push       = s_valid && s_ready;
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = mem[rd_ptr_q];

    // Storage write; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM and datapath
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the FSM only moves on baud ticks.
    always_comb begin
        state_d = state_q;
        if (baud_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_d = StStart;
                    end
                end
                StStart: begin
                    state_d = StData;
                end
                StData: begin
                    if (bit_cnt_q >= NumData) begin
                        state_d = (PARITY != 0) ? StPar : StStop;
                    end
                end
                StPar: begin
                    state_d = StStop;
                end
                StStop: begin
                    if (stop_cnt_q >= NumStop) begin
                        // Back-to-back frames skip IDLE entirely.
                        state_d = fifo_empty ? StIdle : StStart;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Output and datapath next values; everything holds between ticks.
    always_comb begin
        pop        = 1'b0;
        txd_d      = txd_q;
        busy_d     = busy_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        if (baud_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        txd_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                StStart: begin
                    txd_d     = shift_q[0];
                    bit_cnt_d = 4'd1;
                    par_d     = ParInit ^ shift_q[0];
                end
                StData: begin
                    if (bit_cnt_q < NumData) begin
                        // Bit 1 of the current shift value becomes the new LSB.
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        par_d     = par_q ^ shift_q[1];
                    end else if (PARITY != 0) begin
                        txd_d = par_q;
                    end else begin
                        txd_d      = 1'b1;
                        stop_cnt_d = 2'd1;
                    end
                end
                StPar: begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 2'd1;
                end
                StStop: begin
                    if (stop_cnt_q < NumStop) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                        txd_d      = 1'b1;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        txd_d   = 1'b0;
                    end else begin
                        txd_d  = 1'b1;
                        busy_d = 1'b0;
                    end
                end
                default: begin
                    txd_d  = 1'b1;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers; reset aborts any frame and returns the line to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            par_q      <= 1'b0;
        end else begin
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
        end
    end

    assign txd        = txd_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default framing, parity modes, two stop
// bits, FIFO full/refill, mid-frame reset and idle behaviour.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       baud_tick;
    logic [7:0] s_data;
    logic       v_def, v_ev, v_od, v_s2;

    logic       r_def, t_def, b_def;
    logic [2:0] c_def;
    logic       r_ev, t_ev, b_ev;
    logic [2:0] c_ev;
    logic       r_od, t_od, b_od;
    logic [2:0] c_od;
    logic       r_s2, t_s2, b_s2;
    logic [2:0] c_s2;

    uart_tx_fifo dut_def (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_data(s_data), .s_valid(v_def),
        .s_ready(r_def), .txd(t_def), .busy(b_def), .fifo_count(c_def)
    );

    uart_tx_fifo #(.PARITY(2)) dut_ev (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_data(s_data), .s_valid(v_ev),
        .s_ready(r_ev), .txd(t_ev), .busy(b_ev), .fifo_count(c_ev)
    );

    uart_tx_fifo #(.PARITY(1)) dut_od (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_data(s_data), .s_valid(v_od),
        .s_ready(r_od), .txd(t_od), .busy(b_od), .fifo_count(c_od)
    );

    uart_tx_fifo #(.STOP_BITS(2)) dut_s2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_data(s_data), .s_valid(v_s2),
        .s_ready(r_s2), .txd(t_s2), .busy(b_s2), .fifo_count(c_s2)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   sel      = 0;
    logic txd_mon, busy_mon;

    // Route the selected instance's line to the frame checker.
    always_comb begin
        if (sel == 1) begin
            txd_mon  = t_s2;
            busy_mon = b_s2;
        end else begin
            txd_mon  = t_def;
            busy_mon = b_def;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs are driven 1 time unit after the previous edge.
    task automatic cyc(input logic t);
        baud_tick = t;
        @(posedge clk);
        #1;
        baud_tick = 1'b0;
    endtask

    // Frame with start bit in bit 0, data LSB-first, one stop bit.
    function automatic logic [31:0] frame8(input logic [7:0] d);
        return {22'b0, 1'b1, d, 1'b0};
    endfunction

    // Check bit periods first..n-1 of a bit string on the monitored line.
    task automatic expect_bits(input string tag, input logic [31:0] bits, input int first,
                               input int n);
        for (int i = first; i < n; i++) begin
            cyc(1'b1);
            chk({tag, "_txd"}, 32'(txd_mon), 32'(bits[i]));
            chk({tag, "_busy"}, 32'(busy_mon), 32'd1);
            repeat (3) cyc(1'b0);
            chk({tag, "_hold"}, 32'(txd_mon), 32'(bits[i]));
        end
    endtask

    // Run an 11-period parity frame on both parity instances side by side.
    task automatic par_frames(input string tag, input logic [31:0] fe, input logic [31:0] fo);
        for (int i = 0; i < 11; i++) begin
            cyc(1'b1);
            chk({tag, "_even"}, 32'(t_ev), 32'(fe[i]));
            chk({tag, "_odd"}, 32'(t_od), 32'(fo[i]));
            repeat (3) cyc(1'b0);
        end
        cyc(1'b1);
        chk({tag, "_ev_idle"}, 32'(b_ev), 32'd0);
        chk({tag, "_od_idle"}, 32'(b_od), 32'd0);
        repeat (3) cyc(1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected end of sequence");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        baud_tick = 1'b0;
        s_data    = 8'h00;
        v_def     = 1'b0;
        v_ev      = 1'b0;
        v_od      = 1'b0;
        v_s2      = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0);
        rst = 1'b0;

        // Reset state.
        chk("rst_txd", 32'(t_def), 32'd1);
        chk("rst_busy", 32'(b_def), 32'd0);
        chk("rst_count", 32'(c_def), 32'd0);
        chk("rst_ready", 32'(r_def), 32'd1);
        chk("rst_others_ready", 32'({r_ev, r_od, r_s2}), 32'h7);
        chk("rst_others_count", 32'({c_ev, c_od, c_s2}), 32'd0);
        chk("rst_others_line", 32'({t_ev, t_od, t_s2}), 32'h7);

        // Default framing, 0x55.
        s_data = 8'h55;
        v_def  = 1'b1;
        cyc(1'b0);
        v_def = 1'b0;
        chk("push_count", 32'(c_def), 32'd1);
        chk("push_busy", 32'(b_def), 32'd0);
        cyc(1'b1);
        chk("f55_start", 32'(t_def), 32'd0);
        chk("f55_count", 32'(c_def), 32'd0);
        chk("f55_busy", 32'(b_def), 32'd1);
        repeat (3) cyc(1'b0);
        expect_bits("f55", frame8(8'h55), 1, 10);
        cyc(1'b1);
        chk("f55_done_busy", 32'(b_def), 32'd0);
        chk("f55_done_txd", 32'(t_def), 32'd1);
        repeat (3) cyc(1'b0);

        // Parity: 0x07 gives even=1, odd=0; 0x00 gives even=0, odd=1.
        s_data = 8'h07;
        v_ev   = 1'b1;
        v_od   = 1'b1;
        cyc(1'b0);
        v_ev = 1'b0;
        v_od = 1'b0;
        par_frames("p07", {21'b0, 1'b1, 1'b1, 8'h07, 1'b0}, {21'b0, 1'b1, 1'b0, 8'h07, 1'b0});
        s_data = 8'h00;
        v_ev   = 1'b1;
        v_od   = 1'b1;
        cyc(1'b0);
        v_ev = 1'b0;
        v_od = 1'b0;
        par_frames("p00", {21'b0, 1'b1, 1'b0, 8'h00, 1'b0}, {21'b0, 1'b1, 1'b1, 8'h00, 1'b0});

        // Two stop bits, two frames back-to-back: 22 periods of activity.
        sel    = 1;
        s_data = 8'hA3;
        v_s2   = 1'b1;
        cyc(1'b0);
        s_data = 8'h3C;
        cyc(1'b0);
        v_s2 = 1'b0;
        chk("s2_count", 32'(c_s2), 32'd2);
        expect_bits("s2", {10'b0, 2'b11, 8'h3C, 1'b0, 2'b11, 8'hA3, 1'b0}, 0, 22);
        cyc(1'b1);
        chk("s2_done_busy", 32'(b_s2), 32'd0);
        chk("s2_done_txd", 32'(t_s2), 32'd1);
        repeat (3) cyc(1'b0);
        sel = 0;

        // FIFO fill with no ticks, then drain in order.
        v_def = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            s_data = 8'(k);
            cyc(1'b0);
        end
        s_data = 8'h05;
        cyc(1'b0);
        cyc(1'b0);
        chk("full_count", 32'(c_def), 32'd4);
        chk("full_ready", 32'(r_def), 32'd0);
        cyc(1'b1);
        chk("pop_count", 32'(c_def), 32'd3);
        chk("pop_ready", 32'(r_def), 32'd1);
        chk("q1_start", 32'(t_def), 32'd0);
        cyc(1'b0);
        v_def = 1'b0;
        chk("refill_count", 32'(c_def), 32'd4);
        chk("refill_ready", 32'(r_def), 32'd0);
        repeat (2) cyc(1'b0);
        expect_bits("q1", frame8(8'h01), 1, 10);
        expect_bits("q2", frame8(8'h02), 0, 10);
        expect_bits("q3", frame8(8'h03), 0, 10);
        expect_bits("q4", frame8(8'h04), 0, 10);
        expect_bits("q5", frame8(8'h05), 0, 10);
        cyc(1'b1);
        chk("q_done_busy", 32'(b_def), 32'd0);
        repeat (3) cyc(1'b0);
        s_data = 8'h06;
        v_def  = 1'b1;
        cyc(1'b0);
        v_def = 1'b0;
        chk("q6_count", 32'(c_def), 32'd1);
        expect_bits("q6", frame8(8'h06), 0, 10);
        cyc(1'b1);
        chk("q6_done_busy", 32'(b_def), 32'd0);
        repeat (3) cyc(1'b0);

        // Mid-frame reset with two bytes queued; also push and pop together.
        v_def  = 1'b1;
        s_data = 8'h0F;
        cyc(1'b0);
        s_data = 8'hAA;
        cyc(1'b0);
        s_data = 8'hBB;
        cyc(1'b1);
        v_def = 1'b0;
        chk("pushpop_count", 32'(c_def), 32'd2);
        chk("r0f_start", 32'(t_def), 32'd0);
        repeat (3) cyc(1'b0);
        repeat (4) begin
            cyc(1'b1);
            repeat (3) cyc(1'b0);
        end
        chk("pre_rst_busy", 32'(b_def), 32'd1);
        chk("pre_rst_count", 32'(c_def), 32'd2);
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        chk("mid_rst_txd", 32'(t_def), 32'd1);
        chk("mid_rst_busy", 32'(b_def), 32'd0);
        chk("mid_rst_count", 32'(c_def), 32'd0);
        chk("mid_rst_ready", 32'(r_def), 32'd1);
        for (int p = 0; p < 20; p++) begin
            cyc(1'b1);
            chk("post_rst_txd", 32'(t_def), 32'd1);
            chk("post_rst_busy", 32'(b_def), 32'd0);
            repeat (3) cyc(1'b0);
        end

        // Idle ticks, then a push landing on the same edge as a tick.
        for (int p = 0; p < 25; p++) begin
            cyc(1'b1);
            chk("idle_txd", 32'(t_def), 32'd1);
            chk("idle_busy", 32'(b_def), 32'd0);
            repeat (3) cyc(1'b0);
        end
        s_data = 8'h3A;
        v_def  = 1'b1;
        cyc(1'b1);
        v_def = 1'b0;
        chk("late_count", 32'(c_def), 32'd1);
        chk("late_busy", 32'(b_def), 32'd0);
        chk("late_txd", 32'(t_def), 32'd1);
        repeat (3) cyc(1'b0);
        expect_bits("late", frame8(8'h3A), 0, 10);
        cyc(1'b1);
        chk("late_done_busy", 32'(b_def), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
